// File: rtl/calc_op_sched.sv
// calc_op_sched: multi-cycle add/sub/mul scheduler for the calculator datapath.
// Range-checks the result against 10^DIGITS-1, then streams it to the display
// path as BCD digits, least significant first, one digit per clock.
module calc_op_sched #(
  parameter int unsigned WIDTH  = 27,
  parameter int unsigned DIGITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             digit_valid,
  output logic [3:0]       digit_data,
  output logic [3:0]       digit_pos
);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Least significant decimal digit of v.
  function automatic logic [3:0] low_digit(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] q;
    q = v / WIDTH'(10);
    return 4'(v - q * WIDTH'(10));
  endfunction

  localparam logic [WIDTH-1:0] MaxW    = WIDTH'(pow10(DIGITS) - 64'd1);
  localparam logic [WIDTH:0]   MaxX    = (WIDTH + 1)'(pow10(DIGITS) - 64'd1);
  localparam logic [3:0]       LastPos = 4'(DIGITS - 1);

  localparam logic [3:0] OpAdd = 4'b1010;
  localparam logic [3:0] OpSub = 4'b1011;
  localparam logic [3:0] OpMul = 4'b1100;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMul,
    StEmit,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dvalid_q, dvalid_d;
  logic [3:0]       ddata_q, ddata_d;
  logic [3:0]       dpos_q, dpos_d;

  logic             go_emit, go_err;
  logic [WIDTH-1:0] emit_val;
  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   sum_mul;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    aux_d    = aux_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    dvalid_d = 1'b0;
    ddata_d  = ddata_q;
    dpos_d   = dpos_q;
    go_emit  = 1'b0;
    go_err   = 1'b0;
    emit_val = '0;
    sum_ab   = {1'b0, a_q} + {1'b0, b_q};
    sum_mul  = {1'b0, acc_q} + {1'b0, aux_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StExec;
        end
      end

      StExec: begin
        if (a_q > MaxW || b_q > MaxW) begin
          go_err = 1'b1;
        end else begin
          case (op_q)
            OpAdd: begin
              if (sum_ab > MaxX) begin
                go_err = 1'b1;
              end else begin
                go_emit  = 1'b1;
                emit_val = sum_ab[WIDTH-1:0];
              end
            end
            OpSub: begin
              if (b_q > a_q) begin
                go_err = 1'b1;
              end else begin
                go_emit  = 1'b1;
                emit_val = a_q - b_q;
              end
            end
            OpMul: begin
              // Fewest iterations: count down the smaller operand.
              if (a_q < b_q) begin
                cnt_d = a_q;
                aux_d = b_q;
              end else begin
                cnt_d = b_q;
                aux_d = a_q;
              end
              acc_d = '0;
              if (a_q == '0 || b_q == '0) begin
                go_emit  = 1'b1;
                emit_val = '0;
              end else begin
                state_d = StMul;
              end
            end
            default: go_err = 1'b1;
          endcase
        end
      end

      StMul: begin
        // Overflow is registered and acted on the following cycle, keeping the
        // adder/compare path away from the state decode.
        if (ovf_q) begin
          go_err = 1'b1;
        end else if (sum_mul > MaxX) begin
          ovf_d = 1'b1;
        end else begin
          acc_d = sum_mul[WIDTH-1:0];
          cnt_d = cnt_q - WIDTH'(1);
          if (cnt_q == WIDTH'(1)) begin
            go_emit  = 1'b1;
            emit_val = sum_mul[WIDTH-1:0];
          end
        end
      end

      StEmit: begin
        if (dpos_q == LastPos) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          dvalid_d = 1'b1;
          dpos_d   = dpos_q + 4'd1;
          ddata_d  = low_digit(rem_q);
          rem_d    = rem_q / WIDTH'(10);
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (go_err) begin
      err_d    = 1'b1;
      result_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      state_d  = StDone;
    end

    // Digit 0 is presented on the same edge the result is captured.
    if (go_emit) begin
      result_d = emit_val;
      dvalid_d = 1'b1;
      dpos_d   = 4'd0;
      ddata_d  = low_digit(emit_val);
      rem_d    = emit_val / WIDTH'(10);
      state_d  = StEmit;
    end
  end

  // State and datapath registers; reset aborts any transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      aux_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      dvalid_q <= 1'b0;
      ddata_q  <= '0;
      dpos_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      aux_q    <= aux_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      dvalid_q <= dvalid_d;
      ddata_q  <= ddata_d;
      dpos_q   <= dpos_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign result      = result_q;
  assign digit_valid = dvalid_q;
  assign digit_data  = ddata_q;
  assign digit_pos   = dpos_q;

endmodule

// File: doc/calc_op_sched.md
# calc_op_sched

Multi-cycle operation scheduler for the calculator datapath. It accepts one operand pair and an operation code per transaction, performs add, subtract, or multiply (multiply by successive addition), and range-checks the result. It then streams the result to the display path as decimal digits, least significant first, one digit per clock on `digit_data`/`digit_pos`. The block sits between the keypad/operand-entry FSM, which supplies `a`, `b`, `op` and `start`, and the 8-digit display driver.

## Interface
Parameters:
- `WIDTH`, default 27: operand and result width. Must hold `MAXVAL`.
- `DIGITS`, default 8: number of displayed decimal digits. `MAXVAL = 10^DIGITS - 1` (99 999 999).

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low. Asserted at 0.
- `start`, in, 1: request; sampled only in IDLE.
- `op`, in, 4: operation code. 4'b1010 add, 4'b1011 sub, 4'b1100 mul; any other value is an error.
- `a`, in, WIDTH: first operand, unsigned.
- `b`, in, WIDTH: second operand, unsigned.
- `busy`, out, 1: transaction in progress.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: last transaction failed. Sticky until the next accepted `start`.
- `result`, out, WIDTH: last result. 0 on error.
- `digit_valid`, out, 1: `digit_data`/`digit_pos` are valid this cycle.
- `digit_data`, out, 4: BCD digit.
- `digit_pos`, out, 4: digit index, 0 = least significant.

## Operation
- All outputs are registered (Moore, from state and datapath registers).
- **Reset values:** `busy`=0, `done`=0, `err`=0, `result`=0, `digit_valid`=0, `digit_data`=0, `digit_pos`=0, state IDLE.
- **States:** IDLE, EXEC, MUL, EMIT, DONE.
- **IDLE:** if `start`=1, latch `a`, `b`, `op`; clear `err`; go to EXEC with `busy`=1. Otherwise stay.
- **EXEC** (1 cycle). Outcome by condition:
  - `a` > MAXVAL or `b` > MAXVAL: error.
  - Invalid `op`: error.
  - Add: `result`=a+b, computed in WIDTH+1 bits. If the sum > MAXVAL, error; else go to EMIT.
  - Sub: if b > a, error (no negative results); else `result`=a-b, go to EMIT.
  - Mul: load `cnt`=min(a,b), `aux`=max(a,b), `acc`=0. If `cnt`=0, set `result`=0 and go to EMIT; else go to MUL.
- **MUL** (one step per cycle):
  - If acc+aux > MAXVAL (compare in WIDTH+1 bits), error.
  - Else acc<=acc+aux and cnt<=cnt-1. When cnt reaches 0 on that step, set `result`=acc+aux and go to EMIT.
- **EMIT** (exactly DIGITS cycles, k = 0..DIGITS-1):
  - `digit_valid`=1, `digit_pos`=k, `digit_data`=k-th decimal digit of `result`.
  - Leading zeros are emitted; no blanking.
  - After k=DIGITS-1, go to DONE.
- **Error** (from any state): `err`<=1, `result`<=0, go straight to DONE. No EMIT.
- **DONE** (1 cycle): `done`=1, `busy`=0; next state IDLE. `start` in DONE is ignored.
- `start` while `busy`=1 is ignored. Latched operands are unaffected by input changes mid-transaction.
- `result` and `err` hold from DONE until the next accepted `start`.
- Reset asserted mid-transaction aborts it immediately. All outputs take reset values and no `done` pulse is produced.

## Timing
- Edge E0 samples `start`=1 in IDLE. After E0: state EXEC, `busy`=1.
- Add/sub, success:
  - EMIT digits appear after E1..E8.
  - `done` is high for one cycle after E9.
- Mul with m=min(a,b), m>0:
  - MUL occupies the cycles after E1..Em.
  - EMIT appears after E(m+1)..E(m+8).
  - `done` after E(m+9).
- Mul with m=0: same timing as add.
- Error in EXEC: `done`=1 and `err`=1 after E1.
- Error in MUL at step j (1-based): `done` after E(j+2).
- A new `start` can be accepted at the earliest on the edge after DONE (back in IDLE). Minimum transaction spacing is 11 cycles for add.

## Test plan
- **Reset:** pulse `reset`=0 mid-EMIT of an add. All outputs go to 0 asynchronously. After release, IDLE is held with no `done`.
- **Add:** a=12345, b=678, op=1010.
  - digits 3,2,0,3,1,0,0,0 on pos 0..7 after E1..E8.
  - `done` after E9, `result`=13023, `err`=0.
- **Sub underflow and invalid op:**
  - a=5, b=9, op=1011 gives `done`+`err`=1 after E1, `result`=0, no `digit_valid`.
  - op=1110 behaves the same way.
- **Mul:** a=7, b=3, op=1100.
  - 3 MUL cycles, `result`=21, digits 1,2,0,0,0,0,0,0.
  - `done` after E12.
  - Repeat with b=0: `result`=0, `done` after E9.
- **Mul overflow:** a=99999999, b=2. Step 2 detects overflow; `done`+`err` after E4, `result`=0.
- **Handshake:** hold `start`=1 continuously with a=1, b=1, add.
  - Exactly one transaction per 11 cycles; no acceptance while `busy` or in DONE.
  - Changing `a` mid-transaction does not alter `result`=2.
